// File: rtl/cv32e40x_pkg.sv
// Shared types for the XIF result buffer: per-entry lifecycle state and the
// transition helpers applied when an FU result or a commit/kill hits an entry.
package cv32e40x_pkg;

    localparam int RD_WIDTH = 5;

    typedef enum logic [2:0] {
        RB_FREE  = 3'd0,
        RB_PEND  = 3'd1,
        RB_DONE  = 3'd2,
        RB_CMT   = 3'd3,
        RB_READY = 3'd4,
        RB_KILL  = 3'd5,
        RB_KDONE = 3'd6
    } entry_state_e;

    function automatic entry_state_e rb_apply_fu(input entry_state_e s);
        case (s)
            RB_PEND: return RB_DONE;
            RB_CMT:  return RB_READY;
            RB_KILL: return RB_KDONE;
            default: return s;
        endcase
    endfunction

    // Applied after rb_apply_fu so a same-cycle result and commit compose.
    function automatic entry_state_e rb_apply_commit(input entry_state_e s, input logic kill);
        if (kill) begin
            case (s)
                RB_PEND, RB_CMT:   return RB_KILL;
                RB_DONE, RB_READY: return RB_KDONE;
                default:           return s;
            endcase
        end else begin
            case (s)
                RB_PEND: return RB_CMT;
                RB_DONE: return RB_READY;
                default: return s;
            endcase
        end
    endfunction

endpackage

// File: rtl/cv32e40x_xif_result_buffer_if.sv
// Signal bundle between the issue stage / AES FU / commit source and the
// result buffer, plus the XIF result channel and status flags.
interface cv32e40x_xif_result_buffer_if
    import cv32e40x_pkg::*;
#(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32
);
    logic                   alloc_valid_i;
    logic                   alloc_ready_o;
    logic [X_ID_WIDTH-1:0]  alloc_id_i;
    logic [RD_WIDTH-1:0]    alloc_rd_i;

    logic                   fu_valid_i;
    logic                   fu_ready_o;
    logic [X_ID_WIDTH-1:0]  fu_id_i;
    logic [X_RFW_WIDTH-1:0] fu_data_i;

    logic                   commit_valid_i;
    logic [X_ID_WIDTH-1:0]  commit_id_i;
    logic                   commit_kill_i;

    logic                   result_valid_o;
    logic                   result_ready_i;
    logic [X_ID_WIDTH-1:0]  result_id_o;
    logic [RD_WIDTH-1:0]    result_rd_o;
    logic [X_RFW_WIDTH-1:0] result_data_o;
    logic                   result_we_o;

    logic                   empty_o;
    logic                   full_o;

    modport slave (
        input  alloc_valid_i, alloc_id_i, alloc_rd_i,
        input  fu_valid_i, fu_id_i, fu_data_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        input  result_ready_i,
        output alloc_ready_o, fu_ready_o,
        output result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
        output empty_o, full_o
    );

    modport master (
        output alloc_valid_i, alloc_id_i, alloc_rd_i,
        output fu_valid_i, fu_id_i, fu_data_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        output result_ready_i,
        input  alloc_ready_o, fu_ready_o,
        input  result_valid_o, result_id_o, result_rd_o, result_data_o, result_we_o,
        input  empty_o, full_o
    );

endinterface

// File: rtl/cv32e40x_xif_result_buffer.sv
// In-order result buffer between the AES FU output and the XIF result channel:
// results and commits arrive in any order, results leave in allocation order.
module cv32e40x_xif_result_buffer
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    cv32e40x_xif_result_buffer_if.slave xif
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;

    logic empty;
    logic full;
    logic alloc_fire;
    logic deq_fire;
    logic result_valid;
    entry_state_e head_state;

    entry_state_e           state_q [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_q    [DEPTH];
    logic [RD_WIDTH-1:0]    rd_q    [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q  [DEPTH];

    logic [DEPTH-1:0] fu_match;
    logic [DEPTH-1:0] commit_match;

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == FULL_COUNT);
    assign alloc_fire = xif.alloc_valid_i && !full;

    assign head_state   = state_q[head_reg];
    assign result_valid = !empty && (head_state == RB_READY);
    // A killed entry that already has its result is retired without a handshake.
    assign deq_fire     = (result_valid && xif.result_ready_i) ||
                          (!empty && (head_state == RB_KDONE));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);

            entry_state_e           state_reg;
            entry_state_e           state_next;
            logic [X_ID_WIDTH-1:0]  id_reg;
            logic [RD_WIDTH-1:0]    rd_reg;
            logic [X_RFW_WIDTH-1:0] data_reg;
            logic                   live;
            logic                   is_alloc;
            logic                   is_pop;

            assign live     = (state_reg != RB_FREE);
            assign is_alloc = alloc_fire && (tail_reg == IDX);
            assign is_pop   = deq_fire && (head_reg == IDX);

            // A commit may target the ID being allocated in this same cycle.
            assign fu_match[gi]     = xif.fu_valid_i && live && (id_reg == xif.fu_id_i);
            assign commit_match[gi] = xif.commit_valid_i &&
                                      ((live && (id_reg == xif.commit_id_i)) ||
                                       (is_alloc && (xif.alloc_id_i == xif.commit_id_i)));

            always_comb begin
                state_next = state_reg;
                if (is_pop) begin
                    state_next = RB_FREE;
                end else if (is_alloc) begin
                    state_next = RB_PEND;
                    if (commit_match[gi]) begin
                        state_next = rb_apply_commit(RB_PEND, xif.commit_kill_i);
                    end
                end else begin
                    if (fu_match[gi]) begin
                        state_next = rb_apply_fu(state_next);
                    end
                    if (commit_match[gi]) begin
                        state_next = rb_apply_commit(state_next, xif.commit_kill_i);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_reg <= RB_FREE;
                    id_reg    <= '0;
                    rd_reg    <= '0;
                    data_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    if (is_alloc) begin
                        id_reg   <= xif.alloc_id_i;
                        rd_reg   <= xif.alloc_rd_i;
                        data_reg <= '0;
                    end else if (fu_match[gi]) begin
                        data_reg <= xif.fu_data_i;
                    end
                end
            end

            assign state_q[gi] = state_reg;
            assign id_q[gi]    = id_reg;
            assign rd_q[gi]    = rd_reg;
            assign data_q[gi]  = data_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({alloc_fire, deq_fire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (alloc_fire) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (deq_fire) begin
                head_reg <= head_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign xif.alloc_ready_o  = !full;
    assign xif.fu_ready_o     = 1'b1;
    assign xif.result_valid_o = result_valid;
    assign xif.result_we_o    = result_valid;
    assign xif.result_id_o    = id_q[head_reg];
    assign xif.result_rd_o    = rd_q[head_reg];
    assign xif.result_data_o  = data_q[head_reg];
    assign xif.empty_o        = empty;
    assign xif.full_o         = full;

endmodule
